// File: rtl/mtf_ctrl_pkg.sv
// Shared types and defaults for the MTF update scheduler.
// Holds the frame FSM state encoding and the neuron-index width helper.
package mtf_ctrl_pkg;

  localparam int unsigned N_NEURONS_DEF = 4;
  localparam int unsigned DW_DEF        = 8;
  localparam int unsigned TIMEOUT_DEF   = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mtf_update_scheduler_if.sv
// Request/response handshake between the scheduler and the shared MTF engine.
// The scheduler drives the request side; the engine answers with done/spike.
interface mtf_update_scheduler_if #(
  parameter int unsigned N_NEURONS = mtf_ctrl_pkg::N_NEURONS_DEF,
  parameter int unsigned DW        = mtf_ctrl_pkg::DW_DEF
);
  localparam int unsigned IW = mtf_ctrl_pkg::idx_width(N_NEURONS);

  logic          eng_start;
  logic [IW-1:0] eng_idx;
  logic [DW-1:0] eng_i_ext;
  logic          eng_done;
  logic          eng_spike;

  modport master (output eng_start, eng_idx, eng_i_ext, input eng_done, eng_spike);
  modport slave  (input eng_start, eng_idx, eng_i_ext, output eng_done, eng_spike);

endinterface

// File: rtl/mtf_inhib_sat.sv
// Mutual-inhibition subtractor: base current minus the weight when inhibited,
// clamped at zero so a strong weight never wraps to a large current.
module mtf_inhib_sat #(
  parameter int unsigned DW = 8
) (
  input  logic [DW-1:0] i_base,
  input  logic [DW-1:0] i_weight,
  input  logic          i_inhibit,
  output logic [DW-1:0] o_current
);

  logic [DW-1:0] w_sub;

  assign w_sub     = i_inhibit ? i_weight : '0;
  assign o_current = (w_sub > i_base) ? '0 : i_base - w_sub;

endmodule

// File: rtl/mtf_update_scheduler.sv
// Time-multiplexes one MTF update engine across N_NEURONS neurons per tick,
// applying pairwise mutual inhibition from the previous frame's spikes.
module mtf_update_scheduler #(
  parameter int unsigned N_NEURONS = mtf_ctrl_pkg::N_NEURONS_DEF,
  parameter int unsigned DW        = mtf_ctrl_pkg::DW_DEF,
  parameter int unsigned TIMEOUT   = mtf_ctrl_pkg::TIMEOUT_DEF
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           tick,
  input  logic                                           enable,
  input  logic                                           cfg_we,
  input  logic [mtf_ctrl_pkg::idx_width(N_NEURONS)-1:0]  cfg_addr,
  input  logic [DW-1:0]                                  cfg_data,
  input  logic [DW-1:0]                                  inhib_w,
  input  logic                                           err_clr,
  mtf_update_scheduler_if.master                         eng,
  output logic [N_NEURONS-1:0]                           spikes,
  output logic                                           frame_valid,
  output logic                                           busy,
  output logic                                           overrun,
  output logic                                           timeout_err
);
  import mtf_ctrl_pkg::*;

  localparam int unsigned IW = idx_width(N_NEURONS);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_e               r_state;
  logic [IW-1:0]        r_idx;
  logic [CW-1:0]        r_wait_cnt;
  logic [DW-1:0]        r_i_base [N_NEURONS];
  logic [N_NEURONS-1:0] r_prev_spikes;
  logic [N_NEURONS-1:0] r_spike_acc;
  logic [N_NEURONS-1:0] r_spikes;
  logic                 r_eng_start;
  logic [IW-1:0]        r_eng_idx;
  logic [DW-1:0]        r_eng_i_ext;
  logic                 r_frame_done;
  logic                 r_frame_valid;
  logic                 r_busy;
  logic                 r_overrun;
  logic                 r_timeout_err;

  logic [IW-1:0]        w_next_idx;
  logic [DW-1:0]        w_i_ext;

  // Index about to be issued: only meaningful on the IDLE->ISSUE and COMMIT->ISSUE edges.
  assign w_next_idx = (r_state == ST_COMMIT) ? r_idx + IW'(1) : '0;

  mtf_inhib_sat #(.DW(DW)) u_inhib (
    .i_base    (r_i_base[w_next_idx]),
    .i_weight  (inhib_w),
    .i_inhibit (r_prev_spikes[w_next_idx ^ IW'(1)]),
    .o_current (w_i_ext)
  );

  // NOTE: the base-current file is reset because a frame may start before any
  // configuration write, and the engine must then see zero current, never X.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) r_i_base[i] <= '0;
    end else if (cfg_we) begin
      r_i_base[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_wait_cnt    <= '0;
      r_prev_spikes <= '0;
      r_spike_acc   <= '0;
      r_spikes      <= '0;
      r_eng_start   <= 1'b0;
      r_eng_idx     <= '0;
      r_eng_i_ext   <= '0;
      r_frame_done  <= 1'b0;
      r_frame_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      // NOTE: these defaults are overridden by later non-blocking assignments in
      // the case below; the last one scheduled wins, which gives set-over-clear.
      r_eng_start   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_valid <= r_frame_done;
      if (err_clr) r_timeout_err <= 1'b0;
      if (tick && r_busy) r_overrun <= 1'b1;
      else if (err_clr)   r_overrun <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (tick && enable) begin
            r_state     <= ST_ISSUE;
            r_busy      <= 1'b1;
            r_idx       <= w_next_idx;
            r_eng_idx   <= w_next_idx;
            r_eng_i_ext <= w_i_ext;
            r_eng_start <= 1'b1;
          end
        end
        ST_ISSUE: begin
          r_state    <= ST_WAIT;
          r_wait_cnt <= '0;
        end
        ST_WAIT: begin
          if (eng.eng_done) begin
            r_spike_acc[r_idx] <= eng.eng_spike;
            r_state            <= ST_COMMIT;
          end else if (r_wait_cnt == CW'(TIMEOUT - 1)) begin
            r_spike_acc[r_idx] <= 1'b0;
            r_timeout_err      <= 1'b1;
            r_state            <= ST_COMMIT;
          end else begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
          end
        end
        ST_COMMIT: begin
          if (r_idx == IW'(N_NEURONS - 1)) begin
            r_spikes      <= r_spike_acc;
            r_prev_spikes <= r_spike_acc;
            r_frame_done  <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= ST_IDLE;
          end else begin
            r_state     <= ST_ISSUE;
            r_idx       <= w_next_idx;
            r_eng_idx   <= w_next_idx;
            r_eng_i_ext <= w_i_ext;
            r_eng_start <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign eng.eng_start = r_eng_start;
  assign eng.eng_idx   = r_eng_idx;
  assign eng.eng_i_ext = r_eng_i_ext;
  assign spikes        = r_spikes;
  assign frame_valid   = r_frame_valid;
  assign busy          = r_busy;
  assign overrun       = r_overrun;
  assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_mtf_update_scheduler.sv
// Self-checking bench for mtf_update_scheduler: directed frames plus randomized
// frames, all compared against a frame-level reference model kept here.
module tb_mtf_update_scheduler;
  import mtf_ctrl_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 255;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic          enable;
  logic          cfg_we;
  logic [IW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic [DW-1:0] inhib_w;
  logic          err_clr;
  logic [N-1:0]  spikes;
  logic          frame_valid;
  logic          busy;
  logic          overrun;
  logic          timeout_err;

  mtf_update_scheduler_if #(.N_NEURONS(N), .DW(DW)) eng_if ();

  mtf_update_scheduler #(.N_NEURONS(N), .DW(DW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .enable      (enable),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .inhib_w     (inhib_w),
    .err_clr     (err_clr),
    .eng         (eng_if),
    .spikes      (spikes),
    .frame_valid (frame_valid),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Reference model state: base currents, last frame's spikes, sticky flags.
  int           m_base [N];
  logic [N-1:0] m_prev;
  bit           m_ovr;
  bit           m_to;
  int           f_dly [N];   // engine answer delay per neuron in WAIT cycles; <0 = never

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input int a, input int d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = IW'(a); cfg_data = DW'(d);
    @(negedge clk);
    cfg_we = 1'b0;
    m_base[a] = d;
  endtask

  task automatic wait_start(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      if (eng_if.eng_start) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic check_quiet(input string tag, input int n);
    int starts;
    int fvs;
    starts = 0; fvs = 0;
    repeat (n) begin
      @(negedge clk);
      if (eng_if.eng_start) starts++;
      if (frame_valid) fvs++;
    end
    check({tag, "_starts"}, starts, 0);
    check({tag, "_fv"}, fvs, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic clear_errors();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    m_ovr = 1'b0; m_to = 1'b0;
    check("clr_overrun", overrun, 0);
    check("clr_timeout", timeout_err, 0);
  endtask

  // One full frame; engine responds per f_dly, optional tick injected while busy,
  // optional base write for neuron 0 on the tick sample edge.
  task automatic run_frame(input string tag, input logic [N-1:0] spk, input int inj,
                           input bit cfg_tick, input int cfg_val);
    int           exp_i [N];
    logic [N-1:0] exp_spk;
    int           t_tick;
    int           exp_lat;
    int           v;
    bit           ok;
    exp_spk = '0;
    exp_lat = 1;
    for (int i = 0; i < N; i++) begin
      v = m_base[i] - (m_prev[i ^ 1] ? int'(inhib_w) : 0);
      exp_i[i] = (v < 0) ? 0 : v;
      exp_lat += (f_dly[i] < 0) ? TO + 2 : f_dly[i] + 3;
    end
    @(negedge clk);
    tick = 1'b1; enable = 1'b1;
    if (cfg_tick) begin cfg_we = 1'b1; cfg_addr = '0; cfg_data = DW'(cfg_val); end
    t_tick = cyc;
    @(negedge clk);
    tick = 1'b0; cfg_we = 1'b0;
    if (cfg_tick) m_base[0] = cfg_val;
    enable = 1'($urandom_range(0, 1));
    for (int i = 0; i < N; i++) begin
      wait_start(300, ok);
      check({tag, "_start"}, ok, 1);
      check({tag, "_idx"}, eng_if.eng_idx, i);
      check({tag, "_iext"}, eng_if.eng_i_ext, exp_i[i]);
      @(negedge clk);
      check({tag, "_start_pulse"}, eng_if.eng_start, 0);
      if (f_dly[i] < 0) begin
        exp_spk[i] = 1'b0;
        m_to = 1'b1;
      end else begin
        tick = (inj == i);
        repeat (f_dly[i]) begin @(negedge clk); tick = 1'b0; end
        eng_if.eng_done = 1'b1; eng_if.eng_spike = spk[i]; exp_spk[i] = spk[i];
        @(negedge clk);
        eng_if.eng_done = 1'b0; eng_if.eng_spike = 1'b0; tick = 1'b0;
        if (inj == i) m_ovr = 1'b1;
      end
    end
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (frame_valid) ok = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_fv"}, ok, 1);
    check({tag, "_latency"}, cyc - t_tick - 1, exp_lat);
    check({tag, "_spikes"}, spikes, exp_spk);
    check({tag, "_timeout_err"}, timeout_err, m_to);
    check({tag, "_overrun"}, overrun, m_ovr);
    check({tag, "_busy"}, busy, 0);
    @(negedge clk);
    check({tag, "_fv_pulse"}, frame_valid, 0);
    m_prev = exp_spk;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    logic [N-1:0] rs;
    int ri;
    reset = 1'b1; tick = 1'b0; enable = 1'b0; cfg_we = 1'b0; cfg_addr = '0;
    cfg_data = '0; inhib_w = '0; err_clr = 1'b0;
    eng_if.eng_done = 1'b0; eng_if.eng_spike = 1'b0;
    for (int i = 0; i < N; i++) m_base[i] = 0;
    m_prev = '0; m_ovr = 1'b0; m_to = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_spikes", spikes, 0);
    check("rst_fv", frame_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_start", eng_if.eng_start, 0);
    check("rst_idx", eng_if.eng_idx, 0);
    check("rst_iext", eng_if.eng_i_ext, 0);
    reset = 1'b0;

    // Basic frame, then inhibition from the previous frame, then saturation.
    cfg_write(0, 10); cfg_write(1, 20); cfg_write(2, 30); cfg_write(3, 40);
    inhib_w = 8'd5;
    f_dly = '{0, 0, 0, 0};
    run_frame("f1", 4'b1010, -1, 1'b0, 0);
    run_frame("f2", 4'b1010, -1, 1'b0, 0);
    inhib_w = 8'd50;
    run_frame("f3_sat", 4'b1010, -1, 1'b0, 0);

    // Engine never answers neuron 2.
    inhib_w = 8'd5;
    f_dly = '{0, 1, -1, 0};
    run_frame("f4_tmo", 4'b1011, -1, 1'b0, 0);
    clear_errors();

    // Tick with enable low in IDLE is ignored.
    @(negedge clk); tick = 1'b1; enable = 1'b0;
    @(negedge clk); tick = 1'b0; enable = 1'b1;
    check_quiet("tick_dis", 8);
    check("tick_dis_ovr", overrun, m_ovr);

    // Tick during WAIT: dropped, flags overrun, no extra frame.
    f_dly = '{0, 2, 0, 1};
    run_frame("f5_ovr", 4'b0110, 1, 1'b0, 0);
    check_quiet("ovr_quiet", 20);

    // Reset during WAIT of neuron 1 followed by a late eng_done.
    @(negedge clk); tick = 1'b1; enable = 1'b1;
    @(negedge clk); tick = 1'b0;
    wait_start(10, ok);
    check("rstmid_start0", ok, 1);
    @(negedge clk); eng_if.eng_done = 1'b1; eng_if.eng_spike = 1'b1;
    @(negedge clk); eng_if.eng_done = 1'b0; eng_if.eng_spike = 1'b0;
    wait_start(10, ok);
    check("rstmid_start1", ok, 1);
    check("rstmid_idx1", eng_if.eng_idx, 1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; eng_if.eng_done = 1'b1; eng_if.eng_spike = 1'b1;
    @(negedge clk); eng_if.eng_done = 1'b0; eng_if.eng_spike = 1'b0;
    for (int i = 0; i < N; i++) m_base[i] = 0;
    m_prev = '0; m_ovr = 1'b0; m_to = 1'b0;
    check("rstmid_busy", busy, 0);
    check("rstmid_start", eng_if.eng_start, 0);
    check("rstmid_idx", eng_if.eng_idx, 0);
    check("rstmid_iext", eng_if.eng_i_ext, 0);
    check("rstmid_spikes", spikes, 0);
    check("rstmid_overrun", overrun, 0);
    check("rstmid_timeout", timeout_err, 0);
    check_quiet("rstmid_quiet", 20);

    // Base currents cleared by reset, then write-on-tick-edge ordering.
    f_dly = '{0, 0, 0, 0};
    run_frame("f6_zero", 4'b0101, -1, 1'b0, 0);
    cfg_write(0, 10); cfg_write(1, 20); cfg_write(2, 30); cfg_write(3, 40);
    run_frame("f7_cfgtick", 4'b0000, -1, 1'b1, 99);
    run_frame("f8_newcfg", 4'b0011, -1, 1'b0, 0);

    // Randomized frames.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++) cfg_write(i, int'($urandom_range(0, 255)));
      inhib_w = DW'($urandom_range(0, 80));
      for (int i = 0; i < N; i++)
        f_dly[i] = ($urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(0, 3));
      rs = N'($urandom);
      ri = int'($urandom_range(0, 7));
      run_frame("rnd", rs, ri, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 1) clear_errors();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
